// File: rtl/rcb_reg_arbiter_if.sv
// Command/response bundle between the register-bus requesters, the arbiter and the register bank.
// Requester slices are packed: addr slice i is [16i+15:16i], wdata slice i is [32i+31:32i].
interface rcb_reg_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_we;
  logic [16*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      busy;
  logic [NREQ-1:0]      done;
  logic [31:0]          rdata;
  logic                 err;
  logic [15:0]          addr;
  logic                 addr_rdy;
  logic [31:0]          data_mosi;
  logic                 data_mosi_rdy;
  logic [31:0]          data_miso;
  logic                 data_miso_rdy;

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata, data_miso, data_miso_rdy,
    output busy, done, rdata, err, addr, addr_rdy, data_mosi, data_mosi_rdy
  );

  modport master (
    output req_vld, req_we, req_addr, req_wdata, data_miso, data_miso_rdy,
    input  busy, done, rdata, err, addr, addr_rdy, data_mosi, data_mosi_rdy
  );
endinterface

// File: rtl/rcb_reg_arbiter.sv
// Arbitrates NREQ one-deep command slots onto the single register-bank port; write done at T+4, read done one cycle after data or after TIMEOUT wait cycles.
// No backpressure: a pulse into an occupied slot is dropped; busy tells requesters when the slot is free again.
module rcb_reg_arbiter #(
  parameter int NREQ     = 3,
  parameter int SPI_PRIO = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk_100m,
  input  logic            rst_syn,
  rcb_reg_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
  localparam logic [IW-1:0] FIRST = (SPI_PRIO != 0) ? IW'(1) : '0;
  localparam logic [9:0]    TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WR, RD_WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   rr_ptr;
  logic [9:0]      timer;
  logic [NREQ-1:0] slot_we;
  logic [15:0]     slot_addr  [NREQ];
  logic [31:0]     slot_wdata [NREQ];

  logic [NREQ-1:0] busy_q;
  logic [NREQ-1:0] done_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [15:0]     addr_q;
  logic            addr_rdy_q;
  logic [31:0]     mosi_q;
  logic            mosi_rdy_q;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [IW-1:0]   idx;

  // Outside IDLE the only granted slot is cur, so in IDLE every busy slot is pending.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = rr_ptr;
    if (SPI_PRIO != 0 && busy_q[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (idx == LAST) ? FIRST : idx + 1'b1;
        if (!win_vld && busy_q[idx]) begin
          win     = idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst_syn) begin
      state      <= IDLE;
      cur        <= '0;
      rr_ptr     <= LAST;
      timer      <= '0;
      slot_we    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      addr_rdy_q <= 1'b0;
      mosi_q     <= '0;
      mosi_rdy_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      addr_rdy_q <= 1'b0;
      mosi_rdy_q <= 1'b0;
      done_q     <= '0;

      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_vld[i] && !busy_q[i]) begin
          busy_q[i]     <= 1'b1;
          slot_we[i]    <= bus.req_we[i];
          slot_addr[i]  <= bus.req_addr[16*i +: 16];
          slot_wdata[i] <= bus.req_wdata[32*i +: 32];
        end
      end

      case (state)
        IDLE: begin
          if (win_vld) begin
            cur        <= win;
            addr_q     <= slot_addr[win];
            addr_rdy_q <= 1'b1;
            state      <= ADDR;
            if (SPI_PRIO == 0 || win != '0) rr_ptr <= win;
          end
        end
        ADDR: begin
          if (slot_we[cur]) begin
            mosi_q     <= slot_wdata[cur];
            mosi_rdy_q <= 1'b1;
            state      <= WR;
          end else begin
            timer <= '0;
            state <= RD_WAIT;
          end
        end
        WR: begin
          rdata_q     <= '0;
          err_q       <= 1'b0;
          done_q[cur] <= 1'b1;
          state       <= DONE;
        end
        RD_WAIT: begin
          // Data arriving on the expiry cycle still counts as a good read.
          if (bus.data_miso_rdy) begin
            rdata_q     <= bus.data_miso;
            err_q       <= 1'b0;
            done_q[cur] <= 1'b1;
            state       <= DONE;
          end else if (timer == TMO_LAST) begin
            rdata_q     <= 32'hDEAD_BEEF;
            err_q       <= 1'b1;
            done_q[cur] <= 1'b1;
            state       <= DONE;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        DONE: begin
          busy_q[cur] <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rdata         = rdata_q;
  assign bus.err           = err_q;
  assign bus.addr          = addr_q;
  assign bus.addr_rdy      = addr_rdy_q;
  assign bus.data_mosi     = mosi_q;
  assign bus.data_mosi_rdy = mosi_rdy_q;

endmodule

// File: tb/tb_rcb_reg_arbiter.sv
// Bench for rcb_reg_arbiter: directed scenarios then random traffic, checked against a transaction-level
// model of slot occupancy, arbitration order and bank response timing.
module tb_rcb_reg_arbiter;
  localparam int NREQ     = 3;
  localparam int SPI_PRIO = 1;
  localparam int TMO      = 8;

  logic clk = 1'b0;
  logic rst_syn;
  always #5 clk = ~clk;

  rcb_reg_arbiter_if #(.NREQ(NREQ)) bus ();

  rcb_reg_arbiter #(.NREQ(NREQ), .SPI_PRIO(SPI_PRIO), .TIMEOUT(TMO)) dut (
    .clk_100m (clk),
    .rst_syn  (rst_syn),
    .bus      (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model of slots
  logic [NREQ-1:0] m_busy    = '0;
  logic [NREQ-1:0] m_served  = '0;
  logic [NREQ-1:0] done_seen = '0;
  logic [NREQ-1:0] m_we      = '0;
  logic [15:0]     m_addr    [NREQ];
  logic [31:0]     m_wdata   [NREQ];
  int              m_acc_cyc [NREQ];
  int              rr        = NREQ - 1;

  // in-flight transaction expectations
  logic        inflight     = 1'b0;
  int          cur_slot     = 0;
  logic        cur_we       = 1'b0;
  logic [31:0] cur_wdata    = '0;
  int          addr_cyc     = 0;
  int          exp_done_cyc = 0;
  logic [31:0] exp_rdata    = '0;
  logic        exp_err      = 1'b0;
  int          exp_addr_cyc = -1;
  int          idle_from    = 0;
  logic [15:0] m_addr_last  = '0;
  logic [31:0] m_mosi_last  = '0;
  logic        rst_chk      = 1'b0;

  // bank behaviour
  int          force_d       = -1;
  logic        force_data_en = 1'b0;
  logic [31:0] force_data    = '0;
  int          bank_fire_cyc = -1;
  logic [31:0] bank_data     = '0;
  logic        stray_en      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pending = accepted, not yet granted, and loaded no later than cycle c.
  function automatic int pick(input int c);
    logic [NREQ-1:0] pend;
    for (int i = 0; i < NREQ; i++)
      pend[i] = m_busy[i] && !m_served[i] && (m_acc_cyc[i] <= c);
    if (SPI_PRIO != 0) begin
      if (pend[0]) return 0;
      for (int k = 1; k < NREQ; k++) begin
        int j;
        j = 1 + (rr + k - 1) % (NREQ - 1);
        if (pend[j]) return j;
      end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (rr + k) % NREQ;
        if (pend[j]) return j;
      end
    end
    return -1;
  endfunction

  // slot acceptance / release, evaluated on the same edge the DUT uses
  always @(posedge clk) begin
    cyc++;
    if (rst_syn) begin
      m_busy        = '0;
      m_served      = '0;
      done_seen     = '0;
      rr            = NREQ - 1;
      inflight      = 1'b0;
      exp_addr_cyc  = -1;
      idle_from     = cyc;
      bank_fire_cyc = -1;
      m_addr_last   = '0;
      m_mosi_last   = '0;
      rst_chk       = 1'b1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_vld[i] && !m_busy[i]) begin
          m_busy[i]    = 1'b1;
          m_served[i]  = 1'b0;
          m_acc_cyc[i] = cyc;
          m_we[i]      = bus.req_we[i];
          m_addr[i]    = bus.req_addr[16*i +: 16];
          m_wdata[i]   = bus.req_wdata[32*i +: 32];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (done_seen[i]) begin
          m_busy[i]    = 1'b0;
          m_served[i]  = 1'b0;
          done_seen[i] = 1'b0;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_chk) begin
      rst_chk = 1'b0;
      chk("rst_busy",     64'(bus.busy), 64'd0);
      chk("rst_done",     64'(bus.done), 64'd0);
      chk("rst_rdata",    64'(bus.rdata), 64'd0);
      chk("rst_err",      64'(bus.err), 64'd0);
      chk("rst_addr",     64'(bus.addr), 64'd0);
      chk("rst_addr_rdy", 64'(bus.addr_rdy), 64'd0);
      chk("rst_mosi",     64'(bus.data_mosi), 64'd0);
      chk("rst_mosi_rdy", 64'(bus.data_mosi_rdy), 64'd0);
    end else begin
      logic [NREQ-1:0] ev;
      logic            exp_mosi;
      chk("strobe_excl", 64'(($countones({bus.addr_rdy, bus.data_mosi_rdy, |bus.done}) <= 1) ? 1 : 0), 64'd1);
      chk("busy", 64'(bus.busy), 64'(m_busy));

      if (bus.addr_rdy || cyc == exp_addr_cyc) begin
        chk("addr_rdy_time", 64'(bus.addr_rdy), 64'((cyc == exp_addr_cyc) ? 1 : 0));
        if (bus.addr_rdy && !inflight) begin
          int w;
          w = pick(cyc - 1);
          if (w < 0) begin
            tests++;
            fails++;
            $display("FAIL grant: addr_rdy with no pending slot (cycle %0d)", cyc);
          end else begin
            m_served[w] = 1'b1;
            if (SPI_PRIO == 0 || w != 0) rr = w;
            cur_slot    = w;
            cur_we      = m_we[w];
            cur_wdata   = m_wdata[w];
            addr_cyc    = cyc;
            inflight    = 1'b1;
            m_addr_last = m_addr[w];
            if (cur_we) begin
              exp_done_cyc = cyc + 2;
              exp_rdata    = '0;
              exp_err      = 1'b0;
            end else begin
              int d;
              logic [31:0] bd;
              d  = (force_d >= 0) ? force_d : int'($urandom_range(0, TMO + 1));
              bd = force_data_en ? force_data : $urandom;
              bank_fire_cyc = cyc + 1 + d;
              bank_data     = bd;
              exp_done_cyc  = (d < TMO) ? cyc + 2 + d : cyc + 1 + TMO;
              exp_rdata     = (d < TMO) ? bd : 32'hDEAD_BEEF;
              exp_err       = (d < TMO) ? 1'b0 : 1'b1;
            end
          end
        end
        exp_addr_cyc = -1;
      end
      chk("addr", 64'(bus.addr), 64'(m_addr_last));

      exp_mosi = inflight && cur_we && (cyc == addr_cyc + 1);
      if (exp_mosi) m_mosi_last = cur_wdata;
      if (exp_mosi || bus.data_mosi_rdy)
        chk("mosi_rdy", 64'(bus.data_mosi_rdy), 64'(exp_mosi));
      chk("data_mosi", 64'(bus.data_mosi), 64'(m_mosi_last));

      ev = '0;
      if (inflight && cyc == exp_done_cyc) ev[cur_slot] = 1'b1;
      if (bus.done != '0 || ev != '0) begin
        chk("done_vec", 64'(bus.done), 64'(ev));
        if (ev != '0) begin
          chk("rdata", 64'(bus.rdata), 64'(exp_rdata));
          chk("err", 64'(bus.err), 64'(exp_err));
          done_seen[cur_slot] = 1'b1;
          inflight  = 1'b0;
          idle_from = cyc + 1;
        end
      end

      if (!inflight && exp_addr_cyc < 0 && cyc >= idle_from && pick(cyc) >= 0)
        exp_addr_cyc = cyc + 1;
    end
  end

  // register bank responder
  initial begin
    bus.data_miso_rdy = 1'b0;
    bus.data_miso     = '0;
    forever begin
      logic fire;
      @(posedge clk);
      #1;
      fire = (cyc == bank_fire_cyc);
      bus.data_miso_rdy = fire || (stray_en && !inflight && $urandom_range(0, 5) == 0);
      bus.data_miso     = fire ? bank_data : $urandom;
    end
  end

  task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [31:0] wd);
    bus.req_vld[i]              = 1'b1;
    bus.req_we[i]               = we;
    bus.req_addr[16*i +: 16]    = a;
    bus.req_wdata[32*i +: 32]   = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_vld = '0;
  endtask

  initial begin
    rst_syn       = 1'b1;
    bus.req_vld   = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) step();
    rst_syn = 1'b0;
    step();

    // single write on requester 1
    set_req(1, 1'b1, 16'h0010, 32'hA5A5_0001);
    step();
    repeat (8) step();

    // SPI read, bank answers three cycles after addr_rdy
    force_d       = 2;
    force_data_en = 1'b1;
    force_data    = 32'h1234_5678;
    set_req(0, 1'b0, 16'h0004, 32'h0);
    step();
    repeat (12) step();
    force_data_en = 1'b0;

    // three simultaneous reads, then reload of requester 1 in and after its done cycle
    force_d = 0;
    set_req(0, 1'b0, 16'h0100, 32'h0);
    set_req(1, 1'b0, 16'h0101, 32'h0);
    set_req(2, 1'b0, 16'h0102, 32'h0);
    step();
    repeat (7) step();
    set_req(1, 1'b0, 16'h0111, 32'h0);
    step();
    set_req(1, 1'b0, 16'h0121, 32'h0);
    step();
    repeat (20) step();

    // timeout, then data on the last wait cycle
    force_d = TMO;
    set_req(2, 1'b0, 16'h0200, 32'h0);
    step();
    repeat (TMO + 8) step();
    force_d = TMO - 1;
    set_req(2, 1'b0, 16'h0201, 32'h0);
    step();
    repeat (TMO + 8) step();

    // reset while slot 1 waits for data and slot 2 is queued
    force_d = TMO + 1;
    set_req(1, 1'b0, 16'h0300, 32'h0);
    set_req(2, 1'b0, 16'h0301, 32'h0);
    step();
    repeat (3) step();
    rst_syn = 1'b1;
    step();
    rst_syn = 1'b0;
    repeat (5) step();
    force_d = -1;
    set_req(0, 1'b1, 16'h0042, 32'hCAFE_0042);
    step();
    repeat (8) step();

    // overrun on requester 2
    set_req(2, 1'b1, 16'h0500, 32'h0000_0005);
    step();
    set_req(2, 1'b1, 16'h0501, 32'h0000_0006);
    step();
    repeat (10) step();

    // random traffic with stray bank strobes outside read waits
    stray_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 5) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
      step();
    end

    // drain
    for (int k = 0; k < 3000 && (m_busy != '0 || inflight); k++) step();
    stray_en = 1'b0;
    if (m_busy != '0 || inflight) begin
      tests++;
      fails++;
      $display("FAIL drain: slots still busy %0h inflight %0d after cycle budget", m_busy, inflight);
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
